// File: rtl/perceptron_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_pipe_ctrl
// Description : Valid/ready pipeline controller for a perceptron datapath.
//               It tracks one valid bit per stage and produces per-stage
//               register enables that collapse bubbles. It keeps an
//               occupancy count and runs a LOAD/RUN/DRAIN mode FSM. In the
//               FSM, upstream acceptance is only allowed in RUN. Weight/bias
//               loads and flush requests first drain the pipeline.
// Ports       : clk         - clock, all state on rising edge
//               reset       - asynchronous active-low reset
//               wb_en_i     - weight/bias load enables (any bit = loading)
//               flush_i     - level request to stop accepting and empty
//               val_i/rdy_o - upstream handshake (rdy_o combinational)
//               val_o/rdy_i - downstream handshake (val_o registered)
//               stage_en_o  - per-stage datapath enables, bit 0 = input
//               occupancy_o - items in flight (registered)
//               busy_o      - occupancy_o != 0
//               state_o     - LOAD=0, RUN=1, DRAIN=2
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_pipe_ctrl #(
    parameter int DEPTH  = 2,
    parameter int NUM_WB = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_WB-1:0] wb_en_i,
    input  logic              flush_i,
    input  logic              val_i,
    output logic              rdy_o,
    output logic              val_o,
    input  logic              rdy_i,
    output logic [DEPTH-1:0]  stage_en_o,
    output logic [CNT_W-1:0]  occupancy_o,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] v_q, v_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [DEPTH-1:0] w_en;
    logic             w_accept;
    logic             w_emit;
    logic             w_wb_any;

    // A stage may advance when its successor advances or when it is empty.
    // This lets an empty slot (bubble) be filled even while the output stalls.
    always_comb begin
        logic chain;
        w_en          = '0;
        chain         = rdy_i | ~v_q[DEPTH-1];
        w_en[DEPTH-1] = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain   = chain | ~v_q[k];
            w_en[k] = chain;
        end
    end

    assign w_wb_any = |wb_en_i;
    assign rdy_o    = w_en[0] & (state_q == ST_RUN);
    assign w_accept = val_i & rdy_o;
    assign w_emit   = v_q[DEPTH-1] & rdy_i;

    // Valid bits move forward only through enabled stages. The others hold.
    always_comb begin
        v_d = v_q;
        if (w_en[0]) begin
            v_d[0] = w_accept;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (w_en[k]) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    // A simultaneous accept and emit leaves the count unchanged. The handshake
    // rules keep the count from going past DEPTH or below zero.
    assign occ_d = occ_q + CNT_W'(w_accept) - CNT_W'(w_emit);

    // The mode FSM uses the registered occupancy, so DRAIN exits one cycle
    // after the last emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (!w_wb_any && !flush_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_wb_any || flush_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ_q == '0) begin
                    if (w_wb_any) begin
                        state_d = ST_LOAD;
                    end else if (!flush_i) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            v_q     <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            occ_q   <= occ_d;
        end
    end

    assign val_o       = v_q[DEPTH-1];
    assign stage_en_o  = w_en;
    assign occupancy_o = occ_q;
    assign busy_o      = (occ_q != '0);
    assign state_o     = state_q;

endmodule
`default_nettype wire
